// File: rtl/game_end_pkg.sv
// Shared types and constants for the end-of-game overlay: game state, font codes,
// message strings and the bundled VGA timing word carried through the delay line.
package game_end_pkg;

  typedef enum logic [1:0] {
    PLAY = 2'd0,
    LOSE = 2'd1,
    WIN  = 2'd2
  } end_state_t;

  // Font ROM is indexed by 7-bit ASCII codes.
  localparam logic [6:0] CH_SPACE = 7'h20;

  localparam int MSG_WIN_LEN  = 7;
  localparam int MSG_LOSE_LEN = 10;
  localparam logic [8*MSG_WIN_LEN-1:0]  MSG_WIN  = "WYGRANA";
  localparam logic [8*MSG_LOSE_LEN-1:0] MSG_LOSE = "PRZEGRALES";

  typedef struct packed {
    logic [10:0] vcount;
    logic        vsync;
    logic        vblnk;
    logic [10:0] hcount;
    logic        hsync;
    logic        hblnk;
    logic [11:0] rgb;
  } vga_sig_t;

endpackage

// File: rtl/vga_if.sv
// VGA timing + colour bundle passed between the stages of the display chain.
interface vga_if;
  logic [10:0] vcount;
  logic        vsync;
  logic        vblnk;
  logic [10:0] hcount;
  logic        hsync;
  logic        hblnk;
  logic [11:0] rgb;

  modport in  (input  vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
  modport out (output vcount, vsync, vblnk, hcount, hsync, hblnk, rgb);
endinterface

// File: rtl/delay.sv
// Generic register delay line: dout_o is din_i delayed by STAGES clock cycles.
module delay #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [STAGES-1:0][WIDTH-1:0] stage_q;

  // NOTE: every stage is reset so the output bundle reads all-zero during reset;
  // sequential state uses non-blocking assignments so stages shift, not collapse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < STAGES; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[STAGES-1];

endmodule

// File: rtl/game_end_msg_rom.sv
// Maps (game state, character index) to the font code of the message character.
module game_end_msg_rom
  import game_end_pkg::*;
(
  input  end_state_t state_i,
  input  logic [3:0] idx_i,
  output logic [6:0] char_code_o
);

  // NOTE: the default assignment first keeps this block purely combinational (no latch).
  always_comb begin
    char_code_o = CH_SPACE;
    unique case (state_i)
      WIN:  if (int'(idx_i) < MSG_WIN_LEN)
              char_code_o = MSG_WIN[8*(MSG_WIN_LEN-1-int'(idx_i)) +: 7];
      LOSE: if (int'(idx_i) < MSG_LOSE_LEN)
              char_code_o = MSG_LOSE[8*(MSG_LOSE_LEN-1-int'(idx_i)) +: 7];
      default: ;
    endcase
  end

endmodule

// File: rtl/game_end_overlay.sv
// End-of-game text overlay: latches PLAY/LOSE/WIN at frame start and draws a scaled,
// optionally blinking message via the font ROM. Define GAME_END_DIM_EN to dim the background.
module game_end_overlay
  import game_end_pkg::*;
#(
  parameter int          TXT_X        = 350,
  parameter int          TXT_Y        = 350,
  parameter int          SCALE_LOG2   = 1,
  parameter int          MAX_LEN      = 16,
  parameter int          HP_W         = 4,
  parameter int          BLINK_FRAMES = 30,
  parameter logic [11:0] WIN_COLOR    = 12'h0F0,
  parameter logic [11:0] LOSE_COLOR   = 12'hF00
) (
  input  logic            clk,
  input  logic            rst_n,
  vga_if.in               in,
  vga_if.out              out,
  input  logic [HP_W-1:0] hp_in,
  input  logic            win_in,
  input  logic            restart,
  input  logic [7:0]      char_line_pixels,
  output logic [10:0]     char_addr,
  output logic [1:0]      end_state
);

  localparam logic [10:0] X0    = 11'(TXT_X);
  localparam logic [10:0] Y0    = 11'(TXT_Y);
  localparam logic [10:0] BOX_H = 11'(16 << SCALE_LOG2);
  localparam int          CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  end_state_t       state_q, state_d;
  logic             restart_q, restart_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic             visible_q, visible_d;
  logic             vblnk_q;
  logic             frame_start;

  assign frame_start = in.vblnk & ~vblnk_q;

  always_comb begin
    state_d     = state_q;
    restart_d   = restart_q | restart;
    blink_cnt_d = blink_cnt_q;
    visible_d   = visible_q;
    if (state_q == PLAY) begin
      restart_d = 1'b0;
      if (frame_start && (win_in || hp_in == '0)) begin
        state_d     = win_in ? WIN : LOSE;
        blink_cnt_d = '0;
        visible_d   = 1'b1;
      end
    end else if (frame_start) begin
      if (restart_q || restart) begin
        state_d   = PLAY;
        restart_d = 1'b0;
      end else if (BLINK_FRAMES != 0) begin
        if (blink_cnt_q == CNT_W'(BLINK_FRAMES - 1)) begin
          blink_cnt_d = '0;
          visible_d   = ~visible_q;
        end else begin
          blink_cnt_d = blink_cnt_q + 1'b1;
        end
      end
    end
  end

  // Text box geometry; the >= tests guard the subtractions against wrap.
  logic [4:0]  msg_len;
  logic [10:0] box_w, rx, ry;
  logic        inbox_c;
  logic [3:0]  idx_c, line_c;
  logic [2:0]  col_c;
  logic [6:0]  char_code;

  always_comb begin
    msg_len = '0;
    if (state_q == WIN)  msg_len = 5'(MSG_WIN_LEN);
    if (state_q == LOSE) msg_len = 5'(MSG_LOSE_LEN);
    if (int'(msg_len) > MAX_LEN) msg_len = 5'(MAX_LEN);
  end

  assign box_w   = 11'(msg_len) << (3 + SCALE_LOG2);
  assign rx      = in.hcount - X0;
  assign ry      = in.vcount - Y0;
  assign inbox_c = (in.hcount >= X0) && (rx < box_w) && (in.vcount >= Y0) && (ry < BOX_H);
  assign idx_c   = 4'(rx >> (3 + SCALE_LOG2));
  assign col_c   = 3'(rx >> SCALE_LOG2);
  assign line_c  = 4'(ry >> SCALE_LOG2);

  game_end_msg_rom u_msg_rom (
    .state_i     (state_q),
    .idx_i       (idx_c),
    .char_code_o (char_code)
  );

  logic        inbox1_q, inbox2_q, ink_q, dim_q;
  logic [2:0]  col1_q, col2_q;
  logic [11:0] color_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLAY;
      restart_q   <= 1'b0;
      blink_cnt_q <= '0;
      visible_q   <= 1'b1;
      vblnk_q     <= 1'b0;
      char_addr   <= '0;
      inbox1_q    <= 1'b0;
      col1_q      <= '0;
      inbox2_q    <= 1'b0;
      col2_q      <= '0;
      ink_q       <= 1'b0;
      dim_q       <= 1'b0;
      color_q     <= '0;
    end else begin
      state_q     <= state_d;
      restart_q   <= restart_d;
      blink_cnt_q <= blink_cnt_d;
      visible_q   <= visible_d;
      vblnk_q     <= in.vblnk;
      char_addr   <= inbox_c ? {char_code, line_c} : {CH_SPACE, 4'h0};
      inbox1_q    <= inbox_c;
      col1_q      <= col_c;
      inbox2_q    <= inbox1_q;
      col2_q      <= col1_q;
      ink_q       <= (state_q != PLAY) && visible_q && inbox2_q && char_line_pixels[3'd7 - col2_q];
      dim_q       <= (state_q != PLAY);
      color_q     <= (state_q == WIN) ? WIN_COLOR : LOSE_COLOR;
    end
  end

  assign end_state = state_q;

  vga_sig_t pipe_in, pipe_out;
  logic [11:0] rgb_o;

  assign pipe_in = {in.vcount, in.vsync, in.vblnk, in.hcount, in.hsync, in.hblnk, in.rgb};

  delay #(.WIDTH($bits(vga_sig_t)), .STAGES(3)) u_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .din_i  (pipe_in),
    .dout_o (pipe_out)
  );

  always_comb begin
    rgb_o = pipe_out.rgb;
`ifdef GAME_END_DIM_EN
    if (dim_q)
      rgb_o = {1'b0, pipe_out.rgb[11:9], 1'b0, pipe_out.rgb[7:5], 1'b0, pipe_out.rgb[3:1]};
`else
    if (dim_q && 1'b0) rgb_o = pipe_out.rgb;
`endif
    if (ink_q) rgb_o = color_q;
    if (pipe_out.hblnk || pipe_out.vblnk) rgb_o = '0;
  end

  assign out.vcount = pipe_out.vcount;
  assign out.vsync  = pipe_out.vsync;
  assign out.vblnk  = pipe_out.vblnk;
  assign out.hcount = pipe_out.hcount;
  assign out.hsync  = pipe_out.hsync;
  assign out.hblnk  = pipe_out.hblnk;
  assign out.rgb    = rgb_o;

endmodule

// File: tb/tb_game_end_overlay.sv
// Directed bench for game_end_overlay with BLINK_FRAMES=2 and a synthetic font ROM.
module tb_game_end_overlay;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  hp_in;
  logic        win_in, restart;
  logic [7:0]  char_line_pixels;
  logic [10:0] char_addr;
  logic [1:0]  end_state;
  int          n_checks = 0;
  int          n_fail   = 0;

  vga_if vin ();
  vga_if vout ();

  always #5 clk = ~clk;

  game_end_overlay #(
    .TXT_X(350), .TXT_Y(350), .SCALE_LOG2(1), .MAX_LEN(16), .HP_W(4),
    .BLINK_FRAMES(2), .WIN_COLOR(12'h0F0), .LOSE_COLOR(12'hF00)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in               (vin),
    .out              (vout),
    .hp_in            (hp_in),
    .win_in           (win_in),
    .restart          (restart),
    .char_line_pixels (char_line_pixels),
    .char_addr        (char_addr),
    .end_state        (end_state)
  );

  // Synthetic 1-cycle synchronous font ROM: byte = {1,code} ^ {line,line}.
  always @(posedge clk)
    char_line_pixels <= {1'b1, char_addr[10:4]} ^ {char_addr[3:0], char_addr[3:0]};

  function automatic logic [11:0] bg(input logic [11:0] c, input logic ended);
`ifdef GAME_END_DIM_EN
    if (ended) return {1'b0, c[11:9], 1'b0, c[7:5], 1'b0, c[3:1]};
`endif
    return c;
  endfunction

  task automatic drive_px(input logic [10:0] h, input logic [10:0] v,
                          input logic [11:0] c, input logic hb);
    vin.hcount = h; vin.vcount = v; vin.rgb = c; vin.hblnk = hb; vin.vblnk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic frame();
    vin.vblnk = 1'b1;
    repeat (2) @(negedge clk);
    vin.vblnk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_checks++; if (vout.rgb !== 12'h000) begin n_fail++; $display("FAIL reset_rgb: got %h expected 000", vout.rgb); end
    n_checks++; if (char_addr !== 11'h000) begin n_fail++; $display("FAIL reset_addr: got %h expected 000", char_addr); end
    n_checks++; if (end_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", end_state); end
    vin.hcount = 11'd100; vin.vcount = 11'd100; vin.rgb = 12'hABC;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++; if (vout.rgb !== 12'h000) begin n_fail++; $display("FAIL lat2_rgb: got %h expected 000", vout.rgb); end
    @(negedge clk);
    n_checks++; if (vout.rgb !== 12'hABC) begin n_fail++; $display("FAIL lat3_rgb: got %h expected abc", vout.rgb); end
    n_checks++; if (vout.hcount !== 11'd100) begin n_fail++; $display("FAIL lat3_hcount: got %0d expected 100", vout.hcount); end
    vin.rgb = 12'h123; vin.hcount = 11'd101;
    repeat (2) @(negedge clk);
    n_checks++; if (vout.rgb !== 12'hABC) begin n_fail++; $display("FAIL lat_hold: got %h expected abc", vout.rgb); end
    @(negedge clk);
    n_checks++; if (vout.rgb !== 12'h123) begin n_fail++; $display("FAIL lat_new: got %h expected 123", vout.rgb); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (vout.rgb !== 12'h000) begin n_fail++; $display("FAIL async_rgb: got %h expected 000", vout.rgb); end
    n_checks++; if (vout.hcount !== 11'd0) begin n_fail++; $display("FAIL async_hcount: got %0d expected 0", vout.hcount); end
    n_checks++; if (char_addr !== 11'h000) begin n_fail++; $display("FAIL async_addr: got %h expected 000", char_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (vout.rgb !== 12'h123) begin n_fail++; $display("FAIL post_reset_rgb: got %h expected 123", vout.rgb); end
  endtask

  task automatic test_lose_blink();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (char_addr !== 11'h200) begin n_fail++; $display("FAIL play_addr: got %h expected 200", char_addr); end
    n_checks++; if (vout.rgb !== 12'h0A5) begin n_fail++; $display("FAIL play_rgb: got %h expected 0a5", vout.rgb); end
    hp_in = 4'd0;
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (end_state !== 2'd0) begin n_fail++; $display("FAIL lose_midframe: got %0d expected 0", end_state); end
    frame();
    n_checks++; if (end_state !== 2'd1) begin n_fail++; $display("FAIL lose_enter: got %0d expected 1", end_state); end
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (char_addr !== 11'h501) begin n_fail++; $display("FAIL lose_addr: got %h expected 501", char_addr); end
    n_checks++; if (vout.rgb !== 12'hF00) begin n_fail++; $display("FAIL lose_ink_f0: got %h expected f00", vout.rgb); end
    drive_px(11'd354, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== bg(12'h0A5, 1'b1)) begin n_fail++; $display("FAIL lose_noink: got %h expected %h", vout.rgb, bg(12'h0A5, 1'b1)); end
    frame();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== 12'hF00) begin n_fail++; $display("FAIL blink_f1: got %h expected f00", vout.rgb); end
    frame();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== bg(12'h0A5, 1'b1)) begin n_fail++; $display("FAIL blink_f2: got %h expected %h", vout.rgb, bg(12'h0A5, 1'b1)); end
    frame();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== bg(12'h0A5, 1'b1)) begin n_fail++; $display("FAIL blink_f3: got %h expected %h", vout.rgb, bg(12'h0A5, 1'b1)); end
    frame();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== 12'hF00) begin n_fail++; $display("FAIL blink_f4: got %h expected f00", vout.rgb); end
    hp_in = 4'd5;
    pulse_restart();
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (end_state !== 2'd1) begin n_fail++; $display("FAIL lose_restart_wait: got %0d expected 1", end_state); end
    frame();
    n_checks++; if (end_state !== 2'd0) begin n_fail++; $display("FAIL lose_restart: got %0d expected 0", end_state); end
    drive_px(11'd350, 11'd352, 12'h0A5, 1'b0);
    n_checks++; if (vout.rgb !== 12'h0A5) begin n_fail++; $display("FAIL play_again_rgb: got %h expected 0a5", vout.rgb); end
  endtask

  task automatic test_win();
    win_in = 1'b1; hp_in = 4'd0;
    frame();
    n_checks++; if (end_state !== 2'd2) begin n_fail++; $display("FAIL win_priority: got %0d expected 2", end_state); end
    win_in = 1'b0; hp_in = 4'd3;
    drive_px(11'd350, 11'd350, 12'h123, 1'b0);
    n_checks++; if (char_addr !== 11'h570) begin n_fail++; $display("FAIL win_addr_w: got %h expected 570", char_addr); end
    n_checks++; if (vout.rgb !== 12'h0F0) begin n_fail++; $display("FAIL win_ink_w: got %h expected 0f0", vout.rgb); end
    drive_px(11'd354, 11'd350, 12'h123, 1'b0);
    n_checks++; if (vout.rgb !== bg(12'h123, 1'b1)) begin n_fail++; $display("FAIL win_noink_w: got %h expected %h", vout.rgb, bg(12'h123, 1'b1)); end
    drive_px(11'd446, 11'd350, 12'h123, 1'b0);
    n_checks++; if (char_addr !== 11'h410) begin n_fail++; $display("FAIL win_addr_a: got %h expected 410", char_addr); end
    n_checks++; if (vout.rgb !== 12'h0F0) begin n_fail++; $display("FAIL win_ink_a: got %h expected 0f0", vout.rgb); end
    drive_px(11'd462, 11'd350, 12'h123, 1'b0);
    n_checks++; if (char_addr !== 11'h200) begin n_fail++; $display("FAIL win_past_end_addr: got %h expected 200", char_addr); end
    n_checks++; if (vout.rgb !== bg(12'h123, 1'b1)) begin n_fail++; $display("FAIL win_past_end: got %h expected %h", vout.rgb, bg(12'h123, 1'b1)); end
    drive_px(11'd350, 11'd382, 12'h123, 1'b0);
    n_checks++; if (char_addr !== 11'h200) begin n_fail++; $display("FAIL win_below_box: got %h expected 200", char_addr); end
    drive_px(11'd350, 11'd350, 12'h123, 1'b1);
    n_checks++; if (vout.rgb !== 12'h000) begin n_fail++; $display("FAIL win_blank: got %h expected 000", vout.rgb); end
  endtask

  task automatic test_restart();
    pulse_restart();
    drive_px(11'd600, 11'd200, 12'h123, 1'b0);
    n_checks++; if (end_state !== 2'd2) begin n_fail++; $display("FAIL win_restart_wait: got %0d expected 2", end_state); end
    frame();
    n_checks++; if (end_state !== 2'd0) begin n_fail++; $display("FAIL win_restart: got %0d expected 0", end_state); end
    pulse_restart();
    frame();
    n_checks++; if (end_state !== 2'd0) begin n_fail++; $display("FAIL play_restart: got %0d expected 0", end_state); end
    hp_in = 4'd0;
    frame();
    n_checks++; if (end_state !== 2'd1) begin n_fail++; $display("FAIL relose: got %0d expected 1", end_state); end
    hp_in = 4'd3;
    frame();
    n_checks++; if (end_state !== 2'd1) begin n_fail++; $display("FAIL stale_flag_f1: got %0d expected 1", end_state); end
    frame();
    n_checks++; if (end_state !== 2'd1) begin n_fail++; $display("FAIL stale_flag_f2: got %0d expected 1", end_state); end
  endtask

  task automatic test_dim();
    logic [11:0] exp_dim;
`ifdef GAME_END_DIM_EN
    exp_dim = 12'h753;
`else
    exp_dim = 12'hFA6;
`endif
    drive_px(11'd600, 11'd200, 12'hFA6, 1'b0);
    n_checks++; if (vout.rgb !== exp_dim) begin n_fail++; $display("FAIL dim_outside: got %h expected %h", vout.rgb, exp_dim); end
    drive_px(11'd354, 11'd352, 12'hFA6, 1'b0);
    n_checks++; if (vout.rgb !== exp_dim) begin n_fail++; $display("FAIL dim_inbox: got %h expected %h", vout.rgb, exp_dim); end
    pulse_restart();
    frame();
    drive_px(11'd600, 11'd200, 12'hFA6, 1'b0);
    n_checks++; if (vout.rgb !== 12'hFA6) begin n_fail++; $display("FAIL dim_play: got %h expected fa6", vout.rgb); end
  endtask

  initial begin
    rst_n = 1'b0; hp_in = 4'd5; win_in = 1'b0; restart = 1'b0;
    vin.hcount = '0; vin.vcount = '0; vin.hsync = 1'b0; vin.vsync = 1'b0;
    vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = '0;
    repeat (3) @(negedge clk);
    test_reset();
    test_lose_blink();
    test_win();
    test_restart();
    test_dim();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
